store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, 2..16).
REQ-002 SHALL have parameter WD_W, default WD_SIZE from PARAMS_pkg, data/address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports st_valid_i, ld_valid_i, fence_i  input  1  each  store request, load request and drain-all request from the memory stage.
REQ-006 SHALL have ports addr_i  input  WD_W  and  st_data_i  input  WD_W  carrying the byte address and the unaligned store data.
REQ-007 SHALL have port width_i  input  FUNCT3_SIZE  carrying the load/store funct3 (byte, half or word).
REQ-008 SHALL have ports ld_data_o  output  WD_W  (raw aligned word) and stall_proc_o  output  1  (hold the pipeline).
REQ-009 SHALL have ports dmem_addr_o  output  WD_W,  dmem_rd_wr_o  output  1  (0 read, 1 write),  dmem_op_en_o  output  1,  dmem_wr_data_o  output  WD_W,  dmem_byte_en_o  output  4,  and  dmem_rd_data_i  input  WD_W  (combinational read).

Function
REQ-010 SHALL convert each accepted store to an entry {word address addr_i[WD_W-1:2], 4-bit byte mask, lane-aligned data}; mask is 0001/0011/1111 shifted by addr_i[1:0] for funct3[1:0] = 0/1/2.
REQ-011 SHALL accept a store in the same cycle, at the tail, when count < DEPTH; when count == DEPTH it SHALL assert stall_proc_o and not accept; there is no same-cycle full bypass.
REQ-012 SHALL drain the head entry to dmem (op_en=1, rd_wr=1, byte_en=mask) in any cycle with count > 0 and no load owning the port; drain takes 1 cycle.
REQ-013 SHALL give a load the dmem port (op_en=1, rd_wr=0) ahead of a drain, except when count == DEPTH: the drain then wins and the load stalls for 1 cycle.
REQ-014 SHALL treat store acceptance and drain in the same cycle as count unchanged with both pointers advanced; pointers wrap modulo DEPTH.
REQ-015 SHALL, while fence_i is high, drain without accepting loads or stores and hold stall_proc_o until count == 0; fence_i with an empty buffer SHALL cost 0 cycles.
REQ-016 SHALL drive dmem_op_en_o = 0 and ld_data_o = 0 in idle cycles.

Reset
REQ-017 SHALL, on reset_n low, clear count and pointers, discard pending stores (no partial write), and drive every output 0 including stall_proc_o.
REQ-018 SHALL leave entry contents undefined after reset; only count qualifies them.

Configuration
REQ-019 SHALL, when STORE_BUFFER_FWD_EN is defined, compare a load against all valid entries: if the youngest matching-word entry's mask covers every load byte, ld_data_o SHALL come from that entry in the same cycle without a dmem read; otherwise, on any overlap, stall_proc_o SHALL stay high until the overlapping entries have drained.
REQ-020 SHALL, when STORE_BUFFER_FWD_EN is undefined, stall any load while count > 0 until the buffer is empty, then read dmem.

Structure
REQ-021 SHALL place the entry struct (word address, mask, data), the mask-from-funct3 function and the DEPTH limits in PARAMS_pkg.
REQ-022 SHALL use one sub-module, sb_fifo (circular storage, pointers, count); match, forwarding and arbitration logic SHALL stay in store_buffer.

Verification
REQ-023 SB SHALL show sb @0x10 data 0x000000AB, then 4 idle cycles: 1 dmem write, addr 0x10, byte_en 0001, wr_data 0x000000AB, count returns to 0.
REQ-024 SHALL with DEPTH=4 issue 5 back-to-back sw: stall_proc_o asserts on the 5th, and the 5th is accepted the cycle after the forced drain, with 5 writes seen in order.
REQ-025 SHALL with FWD_EN run sw 0x11223344 @0x20 then lw @0x20 next cycle: ld_data_o = 0x11223344 with no dmem read that cycle.
REQ-026 SHALL with FWD_EN run sb 0x55 @0x21 then lw @0x20: stall until the entry drains, then dmem read, with ld_data_o byte1 = 0x55.
REQ-027 SHALL issue 3 stores then fence_i: stall_proc_o stays high exactly 3 cycles, with 3 writes observed.
REQ-028 SHALL issue 2 stores then pulse reset_n low mid-drain: after release count = 0, no further dmem writes, and every output is 0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// PARAMS_pkg -- shared types and helpers for the store buffer slice.
//   WD_SIZE       : data/address width of the core (32)
//   FUNCT3_SIZE   : width of the load/store funct3 field
//   SB_DEPTH_MIN/MAX : legal range for the store buffer DEPTH parameter
//   sb_entry_t    : one buffered store {word address, byte mask, lane data}
//   sb_mask()     : byte mask for a funct3 access at a given byte offset
// -----------------------------------------------------------------------------
package PARAMS_pkg;

  localparam int WD_SIZE      = 32;
  localparam int FUNCT3_SIZE  = 3;
  localparam int SB_DEPTH_MIN = 2;
  localparam int SB_DEPTH_MAX = 16;

  typedef struct packed {
    logic [WD_SIZE-3:0] waddr;  // byte address with the two lane bits dropped
    logic [3:0]         mask;   // byte lanes written by this store
    logic [WD_SIZE-1:0] data;   // store data already shifted into its lanes
  } sb_entry_t;

  // Signed and unsigned variants (funct3[2]) share the same footprint.
  // Accesses that overrun the word are truncated at lane 3.
  function automatic logic [3:0] sb_mask(input logic [FUNCT3_SIZE-1:0] funct3,
                                         input logic [1:0]             offset);
    logic [3:0] base;
    case (funct3)
      3'b000, 3'b100: base = 4'b0001;
      3'b001, 3'b101: base = 4'b0011;
      default:        base = 4'b1111;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if -- data-memory port between the store buffer and dmem.
//   master (store buffer): dmem_addr_o, dmem_rd_wr_o (0 read / 1 write),
//                          dmem_op_en_o, dmem_wr_data_o, dmem_byte_en_o out;
//                          dmem_rd_data_i in (combinational read data)
//   slave  (memory)      : the same signals with directions reversed
// -----------------------------------------------------------------------------
interface store_buffer_if
  import PARAMS_pkg::*;
#(
  parameter int WD_W = WD_SIZE
) ();

  logic [WD_W-1:0] dmem_addr_o;
  logic            dmem_rd_wr_o;
  logic            dmem_op_en_o;
  logic [WD_W-1:0] dmem_wr_data_o;
  logic [3:0]      dmem_byte_en_o;
  logic [WD_W-1:0] dmem_rd_data_i;

  modport master (
    output dmem_addr_o, dmem_rd_wr_o, dmem_op_en_o, dmem_wr_data_o, dmem_byte_en_o,
    input  dmem_rd_data_i
  );

  modport slave (
    input  dmem_addr_o, dmem_rd_wr_o, dmem_op_en_o, dmem_wr_data_o, dmem_byte_en_o,
    output dmem_rd_data_i
  );

endinterface

// File: rtl/store_buffer_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo -- circular storage for the store buffer.
//   clk, reset_n : clock, asynchronous active-low reset (pointers and count)
//   push_i       : write entry_i at the tail (caller guarantees not full)
//   entry_i      : entry to store
//   pop_i        : retire the head entry (caller guarantees not empty)
//   head_o       : entry at the head (oldest)
//   count_o      : number of valid entries
//   rd_ptr_o     : head index, so the owner can walk entries oldest-first
//   entries_o    : every storage slot, for address matching
// -----------------------------------------------------------------------------
module sb_fifo
  import PARAMS_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push_i,
  input  sb_entry_t               entry_i,
  input  logic                    pop_i,
  output sb_entry_t               head_o,
  output logic [CW-1:0]           count_o,
  output logic [PW-1:0]           rd_ptr_o,
  output sb_entry_t [DEPTH-1:0]   entries_o
);

  sb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_i) - CW'(pop_i);
    end
  end

  // NOTE: storage has no reset; count alone says which slots hold live stores,
  // and leaving the array unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr] <= entry_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    assign entries_o[i] = mem[i];
  end

  assign head_o   = mem[rd_ptr];
  assign count_o  = count;
  assign rd_ptr_o = rd_ptr;

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer -- posted-store buffer between the memory stage and dmem.
//   clk, reset_n          : clock, asynchronous active-low reset
//   st_valid_i/ld_valid_i : store / load request from the memory stage
//   fence_i               : drain everything before continuing
//   addr_i, st_data_i     : byte address, unaligned store data
//   width_i               : funct3 (byte / half / word)
//   ld_data_o             : raw aligned load word (0 when no load completes)
//   stall_proc_o          : hold the pipeline this cycle
//   dmem                  : data-memory port (store_buffer_if.master)
// Build option: define STORE_BUFFER_FWD_EN to forward loads from buffered
// stores; without it any load waits for the buffer to empty.
// Drain policy: a store or load request takes the memory-stage slot, so the
// head drains in idle slots, when the buffer is full, during a fence, or
// while a load is held back by the buffer.
// -----------------------------------------------------------------------------
module store_buffer
  import PARAMS_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WD_W  = WD_SIZE
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   st_valid_i,
  input  logic                   ld_valid_i,
  input  logic                   fence_i,
  input  logic [WD_W-1:0]        addr_i,
  input  logic [WD_W-1:0]        st_data_i,
  input  logic [FUNCT3_SIZE-1:0] width_i,
  output logic [WD_W-1:0]        ld_data_o,
  output logic                   stall_proc_o,
  store_buffer_if.master         dmem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t             head;
  sb_entry_t             new_entry;
  sb_entry_t [DEPTH-1:0] entries;
  logic [CW-1:0]         count;
  logic [PW-1:0]         rd_ptr;

  logic [3:0]      acc_mask;
  logic [WD_W-3:0] acc_waddr;
  logic            full, empty;
  logic            st_req, ld_req;
  logic            push, drain;
  logic            ld_wait, ld_read_want, ld_read;

  assign acc_mask  = sb_mask(width_i, addr_i[1:0]);
  assign acc_waddr = addr_i[WD_W-1:2];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // A fence owns the cycle; a store wins if the stage ever raises both.
  assign st_req = st_valid_i && !fence_i;
  assign ld_req = ld_valid_i && !fence_i && !st_valid_i;

  assign new_entry = '{waddr: acc_waddr,
                       mask:  acc_mask,
                       data:  st_data_i << {addr_i[1:0], 3'b000}};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (push),
    .entry_i   (new_entry),
    .pop_i     (drain),
    .head_o    (head),
    .count_o   (count),
    .rd_ptr_o  (rd_ptr),
    .entries_o (entries)
  );

`ifdef STORE_BUFFER_FWD_EN
  sb_entry_t     young;
  logic          young_hit, overlap, fwd_hit;
  logic [PW-1:0] idx;

  // Walk oldest to youngest so the last word match is the youngest one.
  // NOTE: every variable gets a default before any conditional write, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    young     = '0;
    young_hit = 1'b0;
    overlap   = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (entries[idx].waddr == acc_waddr)) begin
        young_hit = 1'b1;
        young     = entries[idx];
        if ((entries[idx].mask & acc_mask) != 4'b0000) overlap = 1'b1;
      end
    end
  end

  assign fwd_hit      = ld_req && young_hit && ((young.mask & acc_mask) == acc_mask);
  assign ld_wait      = ld_req && !fwd_hit && overlap;
  assign ld_read_want = ld_req && !fwd_hit && !overlap;
`else
  logic unused_fwd_view;
  assign unused_fwd_view = ^{entries, rd_ptr};
  assign ld_wait         = ld_req && !empty;
  assign ld_read_want    = ld_req && empty;
`endif

  // A full buffer takes the port from a load for one drain cycle.
  assign ld_read = ld_read_want && !full;
  assign push    = st_req && !full;
  assign drain   = !empty && (fence_i || full || ld_wait || !(st_valid_i || ld_valid_i));

  assign stall_proc_o = (fence_i && !empty) || (st_req && full) || ld_wait
                     || (ld_read_want && full);

  always_comb begin
    dmem.dmem_op_en_o   = 1'b0;
    dmem.dmem_rd_wr_o   = 1'b0;
    dmem.dmem_addr_o    = '0;
    dmem.dmem_wr_data_o = '0;
    dmem.dmem_byte_en_o = 4'b0000;
    ld_data_o           = '0;
    if (drain) begin
      dmem.dmem_op_en_o   = 1'b1;
      dmem.dmem_rd_wr_o   = 1'b1;
      dmem.dmem_addr_o    = {head.waddr, 2'b00};
      dmem.dmem_wr_data_o = head.data;
      dmem.dmem_byte_en_o = head.mask;
    end else if (ld_read) begin
      dmem.dmem_op_en_o = 1'b1;
      dmem.dmem_addr_o  = {acc_waddr, 2'b00};
      ld_data_o         = dmem.dmem_rd_data_i;
    end
`ifdef STORE_BUFFER_FWD_EN
    if (fwd_hit) ld_data_o = young.data;
`endif
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  import PARAMS_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        st_valid_i = 1'b0;
  logic        ld_valid_i = 1'b0;
  logic        fence_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] st_data_i = '0;
  logic [2:0]  width_i = '0;
  logic [31:0] ld_data_o;
  logic        stall_proc_o;

  store_buffer_if #(.WD_W(32)) bus ();

  store_buffer #(.DEPTH(4), .WD_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .st_valid_i   (st_valid_i),
    .ld_valid_i   (ld_valid_i),
    .fence_i      (fence_i),
    .addr_i       (addr_i),
    .st_data_i    (st_data_i),
    .width_i      (width_i),
    .ld_data_o    (ld_data_o),
    .stall_proc_o (stall_proc_o),
    .dmem         (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory model: combinational read, byte-enabled write, write log.
  logic [31:0] mem [256] = '{default: '0};
  logic [67:0] wlog [$];

  assign bus.dmem_rd_data_i = mem[bus.dmem_addr_o[9:2]];

  always @(posedge clk) begin
    if (bus.dmem_op_en_o && bus.dmem_rd_wr_o) begin
      for (int b = 0; b < 4; b++)
        if (bus.dmem_byte_en_o[b])
          mem[bus.dmem_addr_o[9:2]][8*b +: 8] <= bus.dmem_wr_data_o[8*b +: 8];
      wlog.push_back({bus.dmem_addr_o, bus.dmem_byte_en_o, bus.dmem_wr_data_o});
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {25'b0, stall_proc_o, bus.dmem_op_en_o, bus.dmem_rd_wr_o, bus.dmem_addr_o,
            bus.dmem_byte_en_o, bus.dmem_wr_data_o, ld_data_o};
  endfunction

  function automatic logic [127:0] expo(input logic s, input logic op, input logic rw,
                                        input logic [31:0] a, input logic [3:0] be,
                                        input logic [31:0] wd, input logic [31:0] ld);
    return {25'b0, s, op, rw, a, be, wd, ld};
  endfunction

  function automatic logic [127:0] wentry(input int i);
    if (i < wlog.size()) return 128'(wlog[i]);
    return '1;
  endfunction

  function automatic logic [127:0] wexp(input logic [31:0] a, input logic [3:0] be,
                                        input logic [31:0] d);
    return 128'({a, be, d});
  endfunction

  task automatic drive(input logic st, input logic ld, input logic fe,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    st_valid_i = st;
    ld_valid_i = ld;
    fence_i    = fe;
    addr_i     = a;
    st_data_i  = d;
    width_i    = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
    end
  endtask

  // Present a request and hold it until stall_proc_o drops (bounded).
  task automatic issue(input logic st, input logic ld, input logic fe,
                       input logic [31:0] a, input logic [31:0] d, input logic [2:0] w,
                       output int stalls, output logic [31:0] ld_data, output logic rd_seen);
    bit done;
    done    = 1'b0;
    stalls  = 0;
    ld_data = '0;
    rd_seen = 1'b0;
    @(posedge clk); #1;
    drive(st, ld, fe, a, d, w);
    for (int c = 0; c < 32 && !done; c++) begin
      @(negedge clk);
      if (stall_proc_o) stalls++;
      else begin
        done    = 1'b1;
        ld_data = ld_data_o;
        rd_seen = bus.dmem_op_en_o && !bus.dmem_rd_wr_o;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: stall_proc_o still 1 after 32 cycles, required 0");
    end
  endtask

  typedef struct packed {
    logic         st;
    logic         ld;
    logic         fe;
    logic [31:0]  addr;
    logic [31:0]  data;
    logic [2:0]   w;
    logic [127:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic ld, input logic fe,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] w, input logic [127:0] exp);
    vec_t v;
    v.st = st; v.ld = ld; v.fe = fe; v.addr = a; v.data = d; v.w = w; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t        vecs [15];
    int          s;
    logic [31:0] ld;
    logic        rd;

    vecs[0]  = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[1]  = mk(1, 0, 0, 32'h10, 32'hAB,       3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[2]  = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 1, 1, 32'h10, 4'b0001, 32'h000000AB, 32'h0));
    vecs[3]  = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[4]  = mk(1, 0, 0, 32'h16, 32'hBEEF,     3'd1, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[5]  = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 1, 1, 32'h14, 4'b1100, 32'hBEEF0000, 32'h0));
    vecs[6]  = mk(1, 0, 0, 32'h13, 32'hCD,       3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[7]  = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 1, 1, 32'h10, 4'b1000, 32'hCD000000, 32'h0));
    vecs[8]  = mk(0, 1, 0, 32'h10, 32'h0,        3'd2, expo(0, 1, 0, 32'h10, 4'b0000, 32'h0,        32'hCD0000AB));
    vecs[9]  = mk(0, 1, 0, 32'h14, 32'h0,        3'd2, expo(0, 1, 0, 32'h14, 4'b0000, 32'h0,        32'hBEEF0000));
    vecs[10] = mk(0, 0, 1, 32'h00, 32'h0,        3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[11] = mk(1, 0, 0, 32'h18, 32'h12345678, 3'd2, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));
    vecs[12] = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 1, 1, 32'h18, 4'b1111, 32'h12345678, 32'h0));
    vecs[13] = mk(0, 1, 0, 32'h1A, 32'h0,        3'd1, expo(0, 1, 0, 32'h18, 4'b0000, 32'h0,        32'h12345678));
    vecs[14] = mk(0, 0, 0, 32'h00, 32'h0,        3'd0, expo(0, 0, 0, 32'h0,  4'b0000, 32'h0,        32'h0));

    // Reset state.
    #2;
    check("reset_outputs", outs(), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Single-cycle vectors.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].st, vecs[i].ld, vecs[i].fe, vecs[i].addr, vecs[i].data, vecs[i].w);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    check("table_write_count", 128'(wlog.size()), 128'd4);
    check("sb_write", wentry(0), wexp(32'h10, 4'b0001, 32'h000000AB));

    // Five back-to-back word stores into a 4-deep buffer.
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      issue(1, 0, 0, 32'h40 + 32'(4*i), 32'h100 + 32'(i), 3'd2, s, ld, rd);
      check($sformatf("fill_stall%0d", i), 128'(s), 128'd0);
    end
    issue(1, 0, 0, 32'h50, 32'h104, 3'd2, s, ld, rd);
    check("full_store_stall", 128'(s), 128'd1);
    idle(6);
    check("full_write_count", 128'(wlog.size()), 128'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("full_write%0d", i), wentry(i),
            wexp(32'h40 + 32'(4*i), 4'b1111, 32'h100 + 32'(i)));

    // Fence with three pending stores, then with an empty buffer.
    wlog.delete();
    for (int i = 0; i < 3; i++)
      issue(1, 0, 0, 32'h60 + 32'(4*i), 32'h200 + 32'(i), 3'd2, s, ld, rd);
    issue(0, 0, 1, 32'h0, 32'h0, 3'd0, s, ld, rd);
    check("fence_stall", 128'(s), 128'd3);
    check("fence_write_count", 128'(wlog.size()), 128'd3);
    check("fence_write_last", wentry(2), wexp(32'h68, 4'b1111, 32'h202));
    issue(0, 0, 1, 32'h0, 32'h0, 3'd0, s, ld, rd);
    check("fence_empty_stall", 128'(s), 128'd0);
    idle(1);

    // Load to an unrelated word behind one pending store.
    issue(1, 0, 0, 32'h70, 32'hA5A5A5A5, 3'd2, s, ld, rd);
    issue(0, 1, 0, 32'h24, 32'h0, 3'd2, s, ld, rd);
`ifdef STORE_BUFFER_FWD_EN
    check("ld_other_stall", 128'(s), 128'd0);
`else
    check("ld_other_stall", 128'(s), 128'd1);
`endif
    check("ld_other_data", 128'({rd, ld}), 128'({1'b1, 32'h0}));
    idle(2);

    // Word store followed by a word load of the same address.
    issue(1, 0, 0, 32'h20, 32'h11223344, 3'd2, s, ld, rd);
    issue(0, 1, 0, 32'h20, 32'h0, 3'd2, s, ld, rd);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_word_stall", 128'(s), 128'd0);
    check("fwd_word_data", 128'({rd, ld}), 128'({1'b0, 32'h11223344}));
`else
    check("fwd_word_stall", 128'(s), 128'd1);
    check("fwd_word_data", 128'({rd, ld}), 128'({1'b1, 32'h11223344}));
`endif
    idle(2);

    // Byte store partially covering a later word load.
    issue(1, 0, 0, 32'h21, 32'h55, 3'd0, s, ld, rd);
    issue(0, 1, 0, 32'h20, 32'h0, 3'd2, s, ld, rd);
    check("partial_stall", 128'(s), 128'd1);
    check("partial_data", 128'({rd, ld}), 128'({1'b1, 32'h11225544}));
    idle(1);

    // Word store fully covering a later byte load.
    issue(1, 0, 0, 32'h30, 32'hDEADBEEF, 3'd2, s, ld, rd);
    issue(0, 1, 0, 32'h32, 32'h0, 3'd4, s, ld, rd);
`ifdef STORE_BUFFER_FWD_EN
    check("fwd_byte_stall", 128'(s), 128'd0);
    check("fwd_byte_data", 128'({rd, ld}), 128'({1'b0, 32'hDEADBEEF}));
`else
    check("fwd_byte_stall", 128'(s), 128'd1);
    check("fwd_byte_data", 128'({rd, ld}), 128'({1'b1, 32'hDEADBEEF}));
`endif
    idle(2);

    // Load against a full buffer.
    for (int i = 0; i < 4; i++)
      issue(1, 0, 0, 32'h80 + 32'(4*i), 32'h300 + 32'(i), 3'd2, s, ld, rd);
    issue(0, 1, 0, 32'h90, 32'h0, 3'd2, s, ld, rd);
`ifdef STORE_BUFFER_FWD_EN
    check("full_load_stall", 128'(s), 128'd1);
`else
    check("full_load_stall", 128'(s), 128'd4);
`endif
    check("full_load_data", 128'({rd, ld}), 128'({1'b1, 32'h0}));
    idle(5);

    // Reset pulse in the middle of draining two stores.
    issue(1, 0, 0, 32'hA0, 32'h400, 3'd2, s, ld, rd);
    issue(1, 0, 0, 32'hA4, 32'h401, 3'd2, s, ld, rd);
    idle(1);
    @(posedge clk); #1;
    check("mid_drain", outs(), expo(0, 1, 1, 32'hA4, 4'b1111, 32'h401, 32'h0));
    wlog.delete();
    reset_n = 1'b0;
    #1;
    check("in_reset_outputs", outs(), '0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(4);
    @(negedge clk);
    check("post_reset_outputs", outs(), '0);
    check("post_reset_writes", 128'(wlog.size()), 128'd0);
    issue(0, 0, 1, 32'h0, 32'h0, 3'd0, s, ld, rd);
    check("post_reset_fence", 128'(s), 128'd0);
    issue(1, 0, 0, 32'hB0, 32'h77, 3'd0, s, ld, rd);
    idle(2);
    check("post_reset_store", wentry(0), wexp(32'hB0, 4'b0001, 32'h77));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
